// File: rtl/inst_mem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: data width, NOP encoding
// and loader FSM state type.
package inst_mem_responder_pkg;

    localparam int unsigned DATA_WIDTH = 32;

    // addi x0, x0, 0
    localparam logic [DATA_WIDTH-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE
    } load_state_t;

endpackage

// File: rtl/inst_mem_responder_if.sv
// Fetch port and byte-serial loader port between the core/loader (master) and
// the instruction memory responder (slave).
interface inst_mem_responder_if;
    import inst_mem_responder_pkg::*;

    logic                  i_inst_rd_enable;
    logic [31:0]           i_inst_addr;
    logic [DATA_WIDTH-1:0] o_inst_data;
    logic                  o_stall;
    logic                  o_fault;

    logic                  i_load_start;
    logic                  i_load_valid;
    logic [7:0]            i_load_byte;
    logic                  i_load_last;
    logic                  o_load_ready;
    logic                  o_load_done;
    logic                  o_load_overflow;

    modport master (
        output i_inst_rd_enable, i_inst_addr, i_load_start, i_load_valid, i_load_byte,
               i_load_last,
        input  o_inst_data, o_stall, o_fault, o_load_ready, o_load_done, o_load_overflow
    );

    modport slave (
        input  i_inst_rd_enable, i_inst_addr, i_load_start, i_load_valid, i_load_byte,
               i_load_last,
        output o_inst_data, o_stall, o_fault, o_load_ready, o_load_done, o_load_overflow
    );

endinterface

// File: rtl/inst_mem_responder_packer.sv
// Loader FSM: packs accepted bytes little-endian into words and drives the memory
// write port; also holds the sticky fault and overflow flags.
module inst_load_packer
    import inst_mem_responder_pkg::*;
#(
    parameter int unsigned  DEPTH_WORDS = 1024,
    localparam int unsigned AddrW       = $clog2(DEPTH_WORDS),
    localparam int unsigned PtrW        = AddrW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [7:0]            load_byte,
    input  logic                  load_last,
    input  logic                  fetch_err,
    output logic                  load_ready,
    output logic                  load_done,
    output logic                  load_overflow,
    output logic                  stall,
    output logic                  fault,
    output logic                  we,
    output logic [AddrW-1:0]      waddr,
    output logic [DATA_WIDTH-1:0] wdata
);

    load_state_t           state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [PtrW-1:0]       ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic                  last_q, last_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;
    logic                  fault_q, fault_d;
    logic                  ptr_full;

    // DEPTH_WORDS is a power of two, so ptr >= DEPTH_WORDS is just the top bit.
    assign ptr_full = ptr_q[PtrW-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        buf_d   = buf_q;
        last_d  = last_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        fault_d = fault_q | fetch_err;
        we      = 1'b0;
        if (load_start) begin
            state_d = LOAD;
            cnt_d   = '0;
            ptr_d   = '0;
            buf_d   = '0;
            last_d  = 1'b0;
            ovf_d   = 1'b0;
            fault_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                end
                LOAD: begin
                    if (load_valid) begin
                        buf_d[8*cnt_q +: 8] = load_byte;
                        cnt_d  = cnt_q + 2'd1;
                        last_d = load_last;
                        if (cnt_q == 2'd3 || load_last) begin
                            state_d = WRITE;
                        end
                    end
                end
                WRITE: begin
                    we    = ~ptr_full;
                    ovf_d = ovf_q | ptr_full;
                    // Pointer parks at DEPTH_WORDS so it can never wrap back into the array.
                    if (!ptr_full) begin
                        ptr_d = ptr_q + PtrW'(1);
                    end
                    buf_d  = '0;
                    cnt_d  = '0;
                    last_d = 1'b0;
                    if (last_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            buf_q   <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            buf_q   <= buf_d;
            last_q  <= last_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            fault_q <= fault_d;
        end
    end

    assign load_ready    = (state_q == LOAD);
    assign stall         = (state_q != IDLE);
    assign load_done     = done_q;
    assign load_overflow = ovf_q;
    assign fault         = fault_q;
    assign waddr         = ptr_q[AddrW-1:0];
    assign wdata         = buf_q;

endmodule

// File: rtl/inst_mem_responder.sv
// Instruction memory responder: zero-latency fetch port over a word array that is
// filled by the byte-serial loader.
module inst_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] NOP_INST    = inst_mem_responder_pkg::NOP_INST
) (
    input logic                 clk,
    input logic                 rst,
    inst_mem_responder_if.slave bus
);
    import inst_mem_responder_pkg::*;

    localparam int unsigned AddrW = $clog2(DEPTH_WORDS);

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    logic [29:0]           word_idx;
    logic                  aligned;
    logic                  in_range;
    logic                  fetch_ok;
    logic                  fetch_err;
    logic                  we;
    logic [AddrW-1:0]      waddr;
    logic [DATA_WIDTH-1:0] wdata;

    assign word_idx  = bus.i_inst_addr[31:2];
    assign aligned   = (bus.i_inst_addr[1:0] == 2'b00);
    assign in_range  = (word_idx < 30'(DEPTH_WORDS));
    assign fetch_ok  = bus.i_inst_rd_enable & aligned & in_range & ~bus.o_stall;
    assign fetch_err = bus.i_inst_rd_enable & ~bus.o_stall & (~aligned | ~in_range);

    assign bus.o_inst_data = fetch_ok ? mem[word_idx[AddrW-1:0]] : NOP_INST;

    // Program memory survives reset; only the loader writes it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    inst_load_packer #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_packer (
        .clk          (clk),
        .rst          (rst),
        .load_start   (bus.i_load_start),
        .load_valid   (bus.i_load_valid),
        .load_byte    (bus.i_load_byte),
        .load_last    (bus.i_load_last),
        .fetch_err    (fetch_err),
        .load_ready   (bus.o_load_ready),
        .load_done    (bus.o_load_done),
        .load_overflow(bus.o_load_overflow),
        .stall        (bus.o_stall),
        .fault        (bus.o_fault),
        .we           (we),
        .waddr        (waddr),
        .wdata        (wdata)
    );

endmodule

// File: tb/tb_inst_mem_responder.sv
// Self-checking bench for inst_mem_responder: directed load/fetch sequences, a fetch
// vector table and randomized loads checked against a byte-level memory model.
module tb_inst_mem_responder;

    localparam int unsigned Depth = 8;
    localparam logic [31:0] Nop   = 32'h0000_0013;

    typedef struct {
        logic        en;
        logic [31:0] addr;
        logic [31:0] data;
        logic        fault;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_mem_responder_if ifc ();

    inst_mem_responder #(
        .DEPTH_WORDS(Depth),
        .NOP_INST   (Nop)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc.slave)
    );

    int          n_tests  = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    int          cyc      = 0;
    logic [31:0] mdl_mem   [Depth];
    bit          mdl_known [Depth];
    logic        exp_fault = 1'b0;
    logic        exp_ovf   = 1'b0;
    logic [7:0]  tx_q [$];
    vec_t        vecs [12];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ifc.o_load_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish, expected finish before 2ms");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Call at a negedge; returns at the following negedge.
    task automatic fetch(input logic en, input logic [31:0] addr, input logic [31:0] exp,
                         input string name);
        ifc.i_inst_rd_enable = en;
        ifc.i_inst_addr      = addr;
        #1;
        check(name, ifc.o_inst_data, exp);
        @(negedge clk);
        ifc.i_inst_rd_enable = 1'b0;
    endtask

    task automatic mdl_fetch(input logic en, input logic [31:0] addr);
        int unsigned idx;
        bit          ok;
        logic [31:0] exp;
        idx = int'(addr >> 2);
        ok  = en && (addr[1:0] == 2'b00) && (idx < Depth);
        exp = Nop;
        if (ok) exp = mdl_mem[idx];
        if (en && !ok) exp_fault = 1'b1;
        if (!ok || mdl_known[idx]) begin
            fetch(en, addr, exp, $sformatf("rand_fetch_%h", addr));
        end else begin
            ifc.i_inst_rd_enable = en;
            ifc.i_inst_addr      = addr;
            @(negedge clk);
            ifc.i_inst_rd_enable = 1'b0;
        end
        check("rand_fault", ifc.o_fault, exp_fault);
    endtask

    task automatic pulse_start();
        ifc.i_load_start = 1'b1;
        @(negedge clk);
        ifc.i_load_start = 1'b0;
        exp_fault = 1'b0;
        exp_ovf   = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic l);
        int guard;
        guard = 0;
        ifc.i_load_valid = 1'b1;
        ifc.i_load_byte  = b;
        ifc.i_load_last  = l;
        while (ifc.o_load_ready !== 1'b1 && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        n_tests++;
        if (guard >= 8) begin
            n_fail++;
            $display("FAIL ready_wait: got ready=0 for %0d cycles, expected ready within 8", guard);
        end
        @(negedge clk);
        ifc.i_load_valid = 1'b0;
        ifc.i_load_last  = 1'b0;
    endtask

    task automatic wait_done(output int at_cyc);
        int guard;
        bit stall_ok;
        guard    = 0;
        stall_ok = 1'b1;
        while (ifc.o_load_done !== 1'b1 && guard < 16) begin
            if (ifc.o_stall !== 1'b1) stall_ok = 1'b0;
            @(negedge clk);
            guard++;
        end
        check("done_seen", ifc.o_load_done, 1);
        check("stall_high_until_done", stall_ok, 1);
        check("stall_low_at_done", ifc.o_stall, 0);
        at_cyc = cyc;
    endtask

    // Full load of tx_q, then fold it into the model the way the loader should.
    task automatic run_load();
        int          c0, c1, d0, n, nw;
        logic [31:0] word;
        n  = tx_q.size();
        d0 = done_cnt;
        pulse_start();
        c0 = cyc;
        for (int i = 0; i < n; i++) send_byte(tx_q[i], i == n - 1);
        wait_done(c1);
        nw = (n + 3) / 4;
        check("load_cycles", c1 - c0, n + nw);
        @(negedge clk);
        check("done_one_pulse", done_cnt - d0, 1);
        check("done_low_after", ifc.o_load_done, 0);
        for (int w = 0; w < nw; w++) begin
            word = 32'h0;
            for (int k = 0; k < 4; k++) begin
                if (4 * w + k < n) word[8*k +: 8] = tx_q[4*w+k];
            end
            if (w < Depth) begin
                mdl_mem[w]   = word;
                mdl_known[w] = 1'b1;
            end
        end
        exp_ovf = (nw > Depth);
        check("overflow_after_load", ifc.o_load_overflow, exp_ovf);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h0,         32'hDDCC_BBAA, 1'b0};
        vecs[1]  = '{1'b1, 32'h4,         32'h0000_FFEE, 1'b0};
        vecs[2]  = '{1'b0, 32'h4,         Nop,           1'b0};
        vecs[3]  = '{1'b0, 32'h2,         Nop,           1'b0};
        vecs[4]  = '{1'b0, 32'(4 * Depth), Nop,          1'b0};
        vecs[5]  = '{1'b1, 32'h2,         Nop,           1'b1};
        vecs[6]  = '{1'b1, 32'h4,         32'h0000_FFEE, 1'b1};
        vecs[7]  = '{1'b1, 32'(4 * Depth), Nop,          1'b1};
        vecs[8]  = '{1'b1, 32'h1,         Nop,           1'b1};
        vecs[9]  = '{1'b0, 32'h0,         Nop,           1'b1};
        vecs[10] = '{1'b1, 32'h0,         32'hDDCC_BBAA, 1'b1};
        vecs[11] = '{1'b1, 32'hFFFF_FFFC, Nop,           1'b1};

        rst                  = 1'b1;
        ifc.i_inst_rd_enable = 1'b0;
        ifc.i_inst_addr      = 32'h0;
        ifc.i_load_start     = 1'b0;
        ifc.i_load_valid     = 1'b0;
        ifc.i_load_byte      = 8'h0;
        ifc.i_load_last      = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_stall", ifc.o_stall, 0);
        check("reset_ready", ifc.o_load_ready, 0);
        check("reset_done", ifc.o_load_done, 0);
        check("reset_fault", ifc.o_fault, 0);
        check("reset_overflow", ifc.o_load_overflow, 0);
        rst = 1'b0;
        @(negedge clk);

        // Two-word program.
        tx_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_load();
        fetch(1'b1, 32'h0, 32'h0000_0013, "prog_word0");
        fetch(1'b1, 32'h4, 32'h0010_0093, "prog_word1");

        // Partial final word is zero-padded.
        tx_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        run_load();
        fetch(1'b1, 32'h4, 32'h0000_FFEE, "pad_word1");

        for (int i = 0; i < 12; i++) begin
            fetch(vecs[i].en, vecs[i].addr, vecs[i].data, $sformatf("vec%0d_data", i));
            check($sformatf("vec%0d_fault", i), ifc.o_fault, vecs[i].fault);
        end
        exp_fault = 1'b1;
        repeat (3) @(negedge clk);
        check("fault_sticky", ifc.o_fault, 1);

        // Restart after two bytes discards them.
        pulse_start();
        check("fault_cleared_by_start", ifc.o_fault, 0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        check("stall_mid_load", ifc.o_stall, 1);
        tx_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_load();
        fetch(1'b1, 32'h0, 32'hEFBE_ADDE, "restart_word0");
        fetch(1'b1, 32'h4, 32'h0000_FFEE, "restart_word1_kept");

        // Overflow: two words past the end are dropped.
        tx_q.delete();
        for (int i = 0; i < 4 * Depth + 8; i++) tx_q.push_back(8'(i + 1));
        run_load();
        check("overflow_set", ifc.o_load_overflow, 1);
        fetch(1'b1, 32'h0, 32'h0403_0201, "ovf_word0");
        fetch(1'b1, 32'(4 * (Depth - 1)), 32'h201F_1E1D, "ovf_last_word");
        repeat (2) @(negedge clk);
        check("overflow_sticky", ifc.o_load_overflow, 1);

        // Stalled fetch, then reset mid-load.
        pulse_start();
        check("overflow_cleared_by_start", ifc.o_load_overflow, 0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        send_byte(8'h77, 1'b0);
        check("stall_during_fetch", ifc.o_stall, 1);
        fetch(1'b1, 32'h0, Nop, "fetch_while_stalled");
        check("no_fault_when_stalled", ifc.o_fault, 0);
        rst = 1'b1;
        #1;
        check("rst_stall", ifc.o_stall, 0);
        check("rst_ready", ifc.o_load_ready, 0);
        check("rst_done", ifc.o_load_done, 0);
        check("rst_fault", ifc.o_fault, 0);
        check("rst_overflow", ifc.o_load_overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        fetch(1'b1, 32'h0, 32'h0403_0201, "word0_after_reset");
        fetch(1'b1, 32'h4, 32'h0807_0605, "word1_after_reset");

        // Randomized loads and fetches against the model.
        for (int it = 0; it < 8; it++) begin
            int n;
            n = $urandom_range(1, 4 * Depth + 8);
            tx_q.delete();
            for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
            run_load();
            for (int f = 0; f < 12; f++) begin
                logic        en;
                logic [31:0] addr;
                en = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 3))
                    0, 1: addr = 32'(4 * $urandom_range(0, Depth - 1));
                    2:    addr = 32'(4 * $urandom_range(0, Depth - 1) + $urandom_range(1, 3));
                    default: addr = 32'(4 * $urandom_range(Depth, Depth + 100));
                endcase
                mdl_fetch(en, addr);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_mem_responder.md
# inst_mem_responder

Responder end of the instruction-fetch interface. Holds program memory and answers fetch requests from the IF stage with zero-latency read data, so the request address and the returned instruction belong to the same cycle. Also contains a byte-serial program loader with a valid/ready handshake and an FSM that packs bytes into little-endian words. While loading, the block stalls the core through `o_stall`; the top level drives the IF stage's `clk_en` low while `o_stall` is high.

## Interface
- `DEPTH_WORDS`, default 1024: memory depth in 32-bit words; must be a power of two.
- `NOP_INST`, default `32'h0000_0013`: returned for any invalid or blocked fetch.
- `clk`  in  1  main clock.
- `rst`  in  1  reset; one clock, asynchronous, active-high.
- `i_inst_rd_enable`  in  1  fetch request.
- `i_inst_addr`  in  32  byte address of the fetch.
- `o_inst_data`  out  32  fetched instruction (combinational).
- `o_stall`  out  1  high while the loader owns memory.
- `o_fault`  out  1  sticky flag: misaligned or out-of-range fetch.
- `i_load_start`  in  1  pulse; starts or restarts a load at word 0.
- `i_load_valid`  in  1  byte valid.
- `i_load_byte`  in  8  program byte.
- `i_load_last`  in  1  marks the final byte; qualified by `i_load_valid`.
- `o_load_ready`  out  1  loader accepts a byte.
- `o_load_done`  out  1  one-cycle pulse when a load completes.
- `o_load_overflow`  out  1  sticky flag: bytes were dropped past `DEPTH_WORDS`.

## Operation
- Word index is `i_inst_addr[31:2]`.
- A fetch is valid when all of these hold: `i_inst_rd_enable`=1, `i_inst_addr[1:0]`=0, index < `DEPTH_WORDS`, and `o_stall`=0.
  - Valid fetch: `o_inst_data` = `mem[index]`.
  - Any other case: `o_inst_data` = `NOP_INST`.
- `o_fault` sets on the next edge after an enabled, unstalled fetch that is misaligned or out of range. It clears only on `rst` or `i_load_start`.
- Loader FSM states: `IDLE`, `LOAD`, `WRITE`.
  - `IDLE` → `LOAD` on `i_load_start`. Byte counter and word pointer are cleared; the packing buffer is cleared to 0.
  - `LOAD`: `o_load_ready`=1. A byte is accepted when `i_load_valid`=1, and is placed at `buffer[8*cnt +: 8]`, giving little-endian order.
    - Move to `WRITE` when the accepted byte is the 4th of a word, or when `i_load_last`=1. On `i_load_last` the remaining buffer bytes stay 0.
  - `WRITE`: `o_load_ready`=0. Writes the buffer to `mem[ptr]` only if `ptr` < `DEPTH_WORDS`; otherwise the write is dropped and `o_load_overflow` sets. Then `ptr`++, the buffer and counter clear, and the state moves:
    - to `IDLE` with `o_load_done`=1 for one cycle, if the last byte was seen;
    - otherwise back to `LOAD`.
- `o_stall` = state ≠ `IDLE`.
- `i_load_start` in `LOAD` or `WRITE` restarts the load:
  - goes to `LOAD`, pointer 0, partial word discarded, no write that cycle;
  - `o_load_overflow` and `o_fault` clear.
- `i_load_valid` in `IDLE` or `WRITE` is ignored; no byte is consumed.
- `ptr` is `$clog2(DEPTH_WORDS)+1` bits wide, so the overflow condition is detectable.

## Timing
- Fetch read latency is 0 cycles: `o_inst_data` is combinational from the address, enable and `o_stall`.
- Byte handshake: a transfer occurs on a rising edge where `i_load_valid` & `o_load_ready` are both high.
- Every 4 bytes cost 5 cycles (4 `LOAD` + 1 `WRITE`).
- `o_stall` rises on the edge that samples `i_load_start`. It falls on the edge that leaves `WRITE` for `IDLE`, the same edge where `o_load_done` rises.
- Reset values:
  - state `IDLE`; `o_stall`, `o_load_ready`, `o_load_done`, `o_fault`, `o_load_overflow` all 0;
  - pointer, counter and buffer 0.
  - Memory contents are not reset and are retained across `rst`.
- Reset during a load: the load aborts immediately. Words already committed stay in memory; the partial word is lost.
- A write to `mem` occurs only in `WRITE`, so a read and a write never coincide in the same cycle.

## Structure
- Add to `riscv_definitions`:
  - `NOP_INST` constant;
  - `load_state_t` enum {`IDLE`, `LOAD`, `WRITE`};
  - reuse of the existing `DATA_WIDTH` (32).
- Sub-module `inst_load_packer` holds the FSM, byte counter, pointer, buffer and flags. It presents a write port (`we`, `waddr`, `wdata`) to the memory array kept in the top module.

## Test plan
- Load bytes 13,00,00,00,93,00,10,00 with `last` on the 8th byte, then fetch addr 0 and 4 → `o_inst_data` = 0x00000013 then 0x00100093; `o_load_done` pulses exactly once.
- Load 6 bytes AA,BB,CC,DD,EE,FF with `last` on the 6th → word1 = 0x0000FFEE; `o_stall` stays high until the `done` edge.
- Fetch addr 0x2 and addr `4*DEPTH_WORDS` → NOP each time; `o_fault`=1 on the next edge and stays 1 until `i_load_start`.
- Assert `i_load_start` after 2 bytes, then load DE,AD,BE,EF with `last` → word0 = 0xEFBEADDE; the partial bytes are not written.
- `DEPTH_WORDS`=4, load 20 bytes → words 0-3 written, `o_load_overflow`=1, the memory region outside the array is not written.
- Fetch with `i_inst_rd_enable`=1 during a load → NOP with `o_stall`=1. Assert `rst` mid-load → all outputs 0 and state `IDLE`; a previously loaded word 0 reads back unchanged.
